// File: rtl/data_mem_split_ctrl.sv
// Load/store controller between a core and a 32-bit word memory.
// Misaligned accesses that cross a word boundary are split into two aligned accesses.
//
// state | meaning
// IDLE  | ready for a request
// ACC0  | first (or only) memory access
// ACC1  | second access of a split request
// FIN   | one-cycle response
module data_mem_split_ctrl #(
    parameter int ADDR_WIDTH  = 32,
    parameter bit MISALIGN_EN = 1'b1
) (
    input  logic                  Clk_Core,
    input  logic                  Rst_Core,
    input  logic                  Req_Valid,
    output logic                  Req_Ready,
    input  logic                  Req_Write,
    input  logic [2:0]            Lw_Sw_OP,
    input  logic [ADDR_WIDTH-1:0] Req_Addr,
    input  logic [31:0]           Register_In_B,
    output logic                  Rsp_Valid,
    output logic [31:0]           Rsp_Data,
    output logic                  Rsp_Fault,
    output logic                  Mem_Read_Ctrl,
    output logic [3:0]            Mem_Write_Ctrl,
    output logic [ADDR_WIDTH-1:0] Mem_Addr,
    output logic [31:0]           Mem_Write_Data,
    input  logic [31:0]           Mem_Read_Data
);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, FIN} state_t;

    state_t                  state_q;
    logic                    write_q;
    logic [1:0]              sz_q;
    logic                    uns_q;
    logic [1:0]              off_q;
    logic                    split_q;
    logic [ADDR_WIDTH-3:0]   word_addr_q;
    logic [3:0]              mask_hi_q;
    logic [31:0]             wdata_hi_q;
    logic [31:0]             word0_q;

    logic                    ready_q;
    logic                    rsp_valid_q;
    logic                    rsp_fault_q;
    logic                    rd_q;
    logic [3:0]              wc_q;
    logic [ADDR_WIDTH-1:0]   maddr_q;
    logic [31:0]             mwd_q;

    // request decode, evaluated on the live inputs at accept time
    logic [1:0]  in_off;
    logic [2:0]  in_size;
    logic        in_cross;
    logic        in_illegal;
    logic        in_fault;
    logic [7:0]  in_ones;
    logic [7:0]  in_mask8;
    logic [63:0] in_wdata64;

    always_comb begin
        in_off = Req_Addr[1:0];
        case (Lw_Sw_OP[1:0])
            2'b00:   begin in_size = 3'd1; in_ones = 8'h01; end
            2'b01:   begin in_size = 3'd2; in_ones = 8'h03; end
            default: begin in_size = 3'd4; in_ones = 8'h0F; end
        endcase
        in_cross   = ({2'b00, in_off} + {1'b0, in_size}) > 4'd4;
        in_illegal = (Lw_Sw_OP[1:0] == 2'b11) || (Lw_Sw_OP == 3'b110) ||
                     (Req_Write && Lw_Sw_OP[2]);
        in_fault   = in_illegal || (in_cross && !MISALIGN_EN);
        in_mask8   = in_ones << in_off;
        in_wdata64 = {32'h0, Register_In_B} << {in_off, 3'b000};
    end

    always_ff @(posedge Clk_Core) begin
        if (Rst_Core) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            sz_q        <= 2'b00;
            uns_q       <= 1'b0;
            off_q       <= 2'b00;
            split_q     <= 1'b0;
            word_addr_q <= '0;
            mask_hi_q   <= 4'h0;
            wdata_hi_q  <= 32'h0;
            word0_q     <= 32'h0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rd_q        <= 1'b0;
            wc_q        <= 4'h0;
            maddr_q     <= '0;
            mwd_q       <= 32'h0;
        end else begin
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rd_q        <= 1'b0;
            wc_q        <= 4'h0;
            maddr_q     <= '0;
            mwd_q       <= 32'h0;
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b1;
                    if (Req_Valid) begin
                        ready_q     <= 1'b0;
                        write_q     <= Req_Write;
                        sz_q        <= Lw_Sw_OP[1:0];
                        uns_q       <= Lw_Sw_OP[2];
                        off_q       <= in_off;
                        split_q     <= in_cross;
                        word_addr_q <= Req_Addr[ADDR_WIDTH-1:2];
                        mask_hi_q   <= in_mask8[7:4];
                        wdata_hi_q  <= in_wdata64[63:32];
                        if (in_fault) begin
                            state_q     <= FIN;
                            rsp_valid_q <= 1'b1;
                            rsp_fault_q <= 1'b1;
                        end else begin
                            state_q <= ACC0;
                            maddr_q <= {Req_Addr[ADDR_WIDTH-1:2], 2'b00};
                            if (Req_Write) begin
                                wc_q  <= in_mask8[3:0];
                                mwd_q <= in_wdata64[31:0];
                            end else begin
                                rd_q <= 1'b1;
                            end
                        end
                    end
                end
                ACC0: begin
                    if (split_q) begin
                        state_q <= ACC1;
                        // next word address wraps naturally at 2^ADDR_WIDTH
                        maddr_q <= {word_addr_q + {{(ADDR_WIDTH-3){1'b0}}, 1'b1}, 2'b00};
                        if (write_q) begin
                            wc_q  <= mask_hi_q;
                            mwd_q <= wdata_hi_q;
                        end else begin
                            rd_q <= 1'b1;
                        end
                    end else begin
                        state_q     <= FIN;
                        rsp_valid_q <= 1'b1;
                    end
                end
                ACC1: begin
                    word0_q     <= Mem_Read_Data;
                    state_q     <= FIN;
                    rsp_valid_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    // load result: memory data is only valid in FIN, so extraction stays combinational
    logic [31:0] lo_word;
    logic [31:0] sel;
    logic [31:0] ext;

    always_comb begin
        lo_word = split_q ? word0_q : Mem_Read_Data;
        case (off_q)
            2'd0:    sel = lo_word;
            2'd1:    sel = {Mem_Read_Data[7:0],  lo_word[31:8]};
            2'd2:    sel = {Mem_Read_Data[15:0], lo_word[31:16]};
            default: sel = {Mem_Read_Data[23:0], lo_word[31:24]};
        endcase
        case (sz_q)
            2'b00:   ext = uns_q ? {24'h0, sel[7:0]}  : {{24{sel[7]}}, sel[7:0]};
            2'b01:   ext = uns_q ? {16'h0, sel[15:0]} : {{16{sel[15]}}, sel[15:0]};
            default: ext = sel;
        endcase
        Rsp_Data = ((state_q == FIN) && !write_q && !rsp_fault_q) ? ext : 32'h0;
    end

    assign Req_Ready      = ready_q;
    assign Rsp_Valid      = rsp_valid_q;
    assign Rsp_Fault      = rsp_fault_q;
    assign Mem_Read_Ctrl  = rd_q;
    assign Mem_Write_Ctrl = wc_q;
    assign Mem_Addr       = maddr_q;
    assign Mem_Write_Data = mwd_q;

endmodule

// File: tb/tb_data_mem_split_ctrl.sv
// Directed bench for data_mem_split_ctrl: vector table plus hand sequences for split,
// wrap, reset-abort and the fault-only configuration.
module tb_data_mem_split_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_write = 1'b0;
    logic [2:0]  f3 = 3'b010;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        req_ready, rsp_valid, rsp_fault, mem_rd;
    logic [31:0] rsp_data, mem_addr, mem_wd, mrd;
    logic [3:0]  mem_wc;

    logic        b_valid = 1'b0;
    logic [2:0]  b_f3 = 3'b010;
    logic [31:0] b_addr = 32'h0;
    logic        b_ready, b_rsp_valid, b_rsp_fault, b_rd;
    logic [31:0] b_rdata, b_maddr, b_mwd;
    logic [3:0]  b_wc;

    always #5 clk = ~clk;

    data_mem_split_ctrl #(.ADDR_WIDTH(32), .MISALIGN_EN(1'b1)) dut (
        .Clk_Core(clk), .Rst_Core(rst), .Req_Valid(req_valid), .Req_Ready(req_ready),
        .Req_Write(req_write), .Lw_Sw_OP(f3), .Req_Addr(addr), .Register_In_B(wdata),
        .Rsp_Valid(rsp_valid), .Rsp_Data(rsp_data), .Rsp_Fault(rsp_fault),
        .Mem_Read_Ctrl(mem_rd), .Mem_Write_Ctrl(mem_wc), .Mem_Addr(mem_addr),
        .Mem_Write_Data(mem_wd), .Mem_Read_Data(mrd));

    data_mem_split_ctrl #(.ADDR_WIDTH(32), .MISALIGN_EN(1'b0)) dut_nomis (
        .Clk_Core(clk), .Rst_Core(rst), .Req_Valid(b_valid), .Req_Ready(b_ready),
        .Req_Write(1'b0), .Lw_Sw_OP(b_f3), .Req_Addr(b_addr), .Register_In_B(32'h0),
        .Rsp_Valid(b_rsp_valid), .Rsp_Data(b_rdata), .Rsp_Fault(b_rsp_fault),
        .Mem_Read_Ctrl(b_rd), .Mem_Write_Ctrl(b_wc), .Mem_Addr(b_maddr),
        .Mem_Write_Data(b_mwd), .Mem_Read_Data(32'h0));

    // word memory model, 256 words indexed by address bits 9:2
    logic        mem_clr = 1'b1;
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
            mrd <= 32'h0;
        end else begin
            if (mem_rd) mrd <= mem[mem_addr[9:2]];
            for (int i = 0; i < 4; i++)
                if (mem_wc[i]) mem[mem_addr[9:2]][8*i +: 8] <= mem_wd[8*i +: 8];
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    logic [31:0] log_addr [1:8];
    logic [31:0] log_wd   [1:8];
    logic [3:0]  log_wc   [1:8];
    logic        log_rd   [1:8];
    int          r_lat, r_strobes;
    logic [31:0] r_data;
    logic        r_fault;

    task automatic run_txn(input logic w, input logic [2:0] op, input logic [31:0] a,
                           input logic [31:0] d);
        @(negedge clk);
        req_valid = 1'b1; req_write = w; f3 = op; addr = a; wdata = d;
        @(posedge clk);
        #1;
        // scramble inputs: the in-flight access must use the latched copy
        req_valid = 1'b0; req_write = ~w; f3 = 3'b010; addr = ~a; wdata = ~d;
        for (int n = 1; n <= 8; n++) begin
            log_addr[n] = 32'h0; log_wd[n] = 32'h0; log_wc[n] = 4'h0; log_rd[n] = 1'b0;
        end
        r_lat = -1; r_strobes = 0; r_data = 32'h0; r_fault = 1'b0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            log_addr[n] = mem_addr; log_wd[n] = mem_wd; log_wc[n] = mem_wc; log_rd[n] = mem_rd;
            if (mem_rd || (mem_wc != 4'h0)) r_strobes++;
            if (rsp_valid) begin
                r_lat = n; r_data = rsp_data; r_fault = rsp_fault;
                break;
            end
        end
    endtask

    typedef struct {
        logic        w;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp_d;
        logic        exp_f;
        int          exp_lat;
    } vec_t;

    vec_t tbl [14];

    int          b_lat;
    logic        b_flt;
    int          b_rds;

    task automatic run_b(input logic [2:0] op, input logic [31:0] a);
        @(negedge clk);
        b_valid = 1'b1; b_f3 = op; b_addr = a;
        @(posedge clk);
        #1;
        b_valid = 1'b0; b_f3 = 3'b010; b_addr = 32'h0;
        b_lat = -1; b_flt = 1'b0; b_rds = 0;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (b_rd) b_rds++;
            if (b_rsp_valid) begin b_lat = n; b_flt = b_rsp_fault; break; end
        end
        @(negedge clk);
        chk("nomis_single_pulse", 32'(b_rsp_valid), 32'h0);
    endtask

    int bad;

    initial begin
        tbl[0]  = '{1'b0, 3'b010, 32'h04, 32'h0,        32'hAABBCCDD, 1'b0, 2};
        tbl[1]  = '{1'b1, 3'b010, 32'h08, 32'h11223344, 32'h0,        1'b0, 2};
        tbl[2]  = '{1'b0, 3'b010, 32'h06, 32'h0,        32'h3344AABB, 1'b0, 3};
        tbl[3]  = '{1'b1, 3'b010, 32'h10, 32'h80FF7F01, 32'h0,        1'b0, 2};
        tbl[4]  = '{1'b0, 3'b000, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0, 2};
        tbl[5]  = '{1'b0, 3'b100, 32'h13, 32'h0,        32'h00000080, 1'b0, 2};
        tbl[6]  = '{1'b0, 3'b000, 32'h11, 32'h0,        32'h0000007F, 1'b0, 2};
        tbl[7]  = '{1'b0, 3'b001, 32'h12, 32'h0,        32'hFFFF80FF, 1'b0, 2};
        tbl[8]  = '{1'b0, 3'b101, 32'h10, 32'h0,        32'h00007F01, 1'b0, 2};
        tbl[9]  = '{1'b0, 3'b011, 32'h00, 32'h0,        32'h0,        1'b1, 1};
        tbl[10] = '{1'b1, 3'b100, 32'h00, 32'h55,       32'h0,        1'b1, 1};
        tbl[11] = '{1'b0, 3'b110, 32'h00, 32'h0,        32'h0,        1'b1, 1};
        tbl[12] = '{1'b0, 3'b111, 32'h04, 32'h0,        32'h0,        1'b1, 1};
        tbl[13] = '{1'b0, 3'b001, 32'h13, 32'h0,        32'h00000080, 1'b0, 3};

        // reset values
        repeat (3) @(negedge clk);
        chk("rst_ready",   32'(req_ready), 32'h1);
        chk("rst_valid",   32'(rsp_valid), 32'h0);
        chk("rst_fault",   32'(rsp_fault), 32'h0);
        chk("rst_data",    rsp_data,       32'h0);
        chk("rst_rd",      32'(mem_rd),    32'h0);
        chk("rst_wc",      32'(mem_wc),    32'h0);
        chk("rst_addr",    mem_addr,       32'h0);
        chk("rst_wd",      mem_wd,         32'h0);
        rst = 1'b0; mem_clr = 1'b0;

        // aligned store: one full-mask strobe
        run_txn(1'b1, 3'b010, 32'h04, 32'hAABBCCDD);
        chk("sw04_lat",     32'(r_lat),     32'd2);
        chk("sw04_wc",      32'(log_wc[1]), 32'hF);
        chk("sw04_addr",    log_addr[1],    32'h04);
        chk("sw04_wd",      log_wd[1],      32'hAABBCCDD);
        chk("sw04_strobes", 32'(r_strobes), 32'd1);

        for (int i = 0; i < 14; i++) begin
            run_txn(tbl[i].w, tbl[i].op, tbl[i].a, tbl[i].d);
            chk($sformatf("v%0d_lat", i),     32'(r_lat),     32'(tbl[i].exp_lat));
            chk($sformatf("v%0d_fault", i),   32'(r_fault),   32'(tbl[i].exp_f));
            chk($sformatf("v%0d_strobes", i), 32'(r_strobes), 32'(tbl[i].exp_lat - 1));
            if (!tbl[i].w && !tbl[i].exp_f)
                chk($sformatf("v%0d_data", i), r_data, tbl[i].exp_d);
        end

        // split halfword store at offset 3
        run_txn(1'b1, 3'b001, 32'h07, 32'h0000F00D);
        chk("sh07_lat",    32'(r_lat),     32'd3);
        chk("sh07_addr0",  log_addr[1],    32'h04);
        chk("sh07_wc0",    32'(log_wc[1]), 32'h8);
        chk("sh07_lane3",  32'(log_wd[1][31:24]), 32'h0D);
        chk("sh07_addr1",  log_addr[2],    32'h08);
        chk("sh07_wc1",    32'(log_wc[2]), 32'h1);
        chk("sh07_lane0",  32'(log_wd[2][7:0]),   32'hF0);
        run_txn(1'b0, 3'b001, 32'h07, 32'h0);
        chk("lh07_data",   r_data,         32'hFFFFF00D);
        chk("lh07_lat",    32'(r_lat),     32'd3);
        run_txn(1'b0, 3'b101, 32'h07, 32'h0);
        chk("lhu07_data",  r_data,         32'h0000F00D);

        // store wrapping past the top of the address space
        run_txn(1'b1, 3'b010, 32'hFFFFFFFE, 32'h12345678);
        chk("wrap_lat",    32'(r_lat),     32'd3);
        chk("wrap_addr0",  log_addr[1],    32'hFFFFFFFC);
        chk("wrap_wc0",    32'(log_wc[1]), 32'hC);
        chk("wrap_wd0",    log_wd[1],      32'h56780000);
        chk("wrap_addr1",  log_addr[2],    32'h00000000);
        chk("wrap_wc1",    32'(log_wc[2]), 32'h3);
        chk("wrap_wd1",    log_wd[2],      32'h00001234);

        // reset during ACC0 of a split store
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; f3 = 3'b010; addr = 32'h0E; wdata = 32'hDEADBEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        chk("abort_acc0_wc", 32'(mem_wc), 32'hC);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_wc",    32'(mem_wc),    32'h0);
        chk("abort_ready", 32'(req_ready), 32'h1);
        chk("abort_valid", 32'(rsp_valid), 32'h0);
        rst = 1'b0;
        bad = 0;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            if (rsp_valid || (mem_wc != 4'h0)) bad++;
        end
        chk("abort_quiet", 32'(bad), 32'h0);
        run_txn(1'b0, 3'b010, 32'h10, 32'h0);
        chk("abort_word10", r_data, 32'h80FF7F01);

        // configuration without misaligned support
        run_b(3'b010, 32'h06);
        chk("nomis_lw06_lat",   32'(b_lat), 32'd1);
        chk("nomis_lw06_fault", 32'(b_flt), 32'h1);
        chk("nomis_lw06_rd",    32'(b_rds), 32'h0);
        run_b(3'b011, 32'h04);
        chk("nomis_f011_lat",   32'(b_lat), 32'd1);
        chk("nomis_f011_fault", 32'(b_flt), 32'h1);
        chk("nomis_f011_rd",    32'(b_rds), 32'h0);
        run_b(3'b010, 32'h04);
        chk("nomis_lw04_lat",   32'(b_lat), 32'd2);
        chk("nomis_lw04_fault", 32'(b_flt), 32'h0);
        chk("nomis_lw04_rd",    32'(b_rds), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
